// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: data cache SRAM-like port to single-beat AXI4 master.
// Optional AXI_RESP_CHK_EN adds a sticky resp_err output for bad R/B responses.
module dcache_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_data_req,
    input  logic        cache_data_wr,
    input  logic [1:0]  cache_data_size,
    input  logic [31:0] cache_data_addr,
    input  logic [31:0] cache_data_wdata,
    output logic [31:0] cache_data_rdata,
    output logic        cache_data_addr_ok,
    output logic        cache_data_data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
`ifdef AXI_RESP_CHK_EN
    ,
    output logic        resp_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WRESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        aw_fire, w_fire;
    logic [2:0]  axsize;
    logic        unused_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        size_d             = size_q;
        wdata_d            = wdata_q;
        aw_done_d          = aw_done_q;
        w_done_d           = w_done_q;
        aw_fire            = 1'b0;
        w_fire             = 1'b0;
        arvalid            = 1'b0;
        rready             = 1'b0;
        awvalid            = 1'b0;
        wvalid             = 1'b0;
        bready             = 1'b0;
        cache_data_addr_ok = 1'b0;
        cache_data_data_ok = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cache_data_req) begin
                    addr_d  = cache_data_addr;
                    size_d  = cache_data_size;
                    wdata_d = cache_data_wdata;
                    state_d = cache_data_wr ? WADDR : RADDR;
                end
            end
            RADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    cache_data_addr_ok = 1'b1;
                    state_d            = RDATA;
                end
            end
            RDATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    cache_data_data_ok = 1'b1;
                    state_d            = IDLE;
                end
            end
            WADDR: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                aw_fire = awvalid & awready;
                w_fire  = wvalid & wready;
                // addr_ok fires once, when the later of AW/W handshakes
                if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
                    cache_data_addr_ok = 1'b1;
                    aw_done_d          = 1'b0;
                    w_done_d           = 1'b0;
                    state_d            = WRESP;
                end else begin
                    aw_done_d = aw_done_q | aw_fire;
                    w_done_d  = w_done_q | w_fire;
                end
            end
            WRESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    cache_data_data_ok = 1'b1;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wstrb = 4'b1111;
        unique case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign axsize           = (size_q == 2'd3) ? 3'b010 : {1'b0, size_q};
    assign cache_data_rdata = rdata;

    assign arid    = RD_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = axsize;
    assign arburst = 2'b01;

    assign awid    = WR_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = axsize;
    assign awburst = 2'b01;

    assign wid   = WR_ID;
    assign wdata = wdata_q;
    assign wlast = 1'b1;

`ifdef AXI_RESP_CHK_EN
    logic resp_err_q, resp_err_d;

    always_ff @(posedge clk) begin
        if (rst) resp_err_q <= 1'b0;
        else     resp_err_q <= resp_err_d;
    end

    always_comb begin
        resp_err_d = resp_err_q;
        if (rvalid && rready && (rresp != 2'b00)) resp_err_d = 1'b1;
        if (bvalid && bready && (bresp != 2'b00)) resp_err_d = 1'b1;
    end

    assign resp_err  = resp_err_q;
    assign unused_in = ^{rid, bid, rlast};
`else
    assign unused_in = ^{rid, bid, rlast, rresp, bresp};
`endif

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: vector table plus stall/reset sequences.
// Define AXI_RESP_CHK_EN to also cover the resp_err flag.
module tb_dcache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdat;
    logic [31:0] c_rdata;
    logic        addr_ok, data_ok;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        rvalid, rready;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        awvalid, awready;
    logic        bvalid, bready;
`ifdef AXI_RESP_CHK_EN
    logic        resp_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dcache_axi_bridge dut (
        .clk                (clk),
        .rst                (rst),
        .cache_data_req     (req),
        .cache_data_wr      (wr),
        .cache_data_size    (size),
        .cache_data_addr    (addr),
        .cache_data_wdata   (wdat),
        .cache_data_rdata   (c_rdata),
        .cache_data_addr_ok (addr_ok),
        .cache_data_data_ok (data_ok),
        .arid               (arid),
        .araddr             (araddr),
        .arlen              (arlen),
        .arsize             (arsize),
        .arburst            (arburst),
        .arvalid            (arvalid),
        .arready            (arready),
        .rid                (4'd0),
        .rdata              (rdata),
        .rresp              (rresp),
        .rlast              (1'b1),
        .rvalid             (rvalid),
        .rready             (rready),
        .awid               (awid),
        .awaddr             (awaddr),
        .awlen              (awlen),
        .awsize             (awsize),
        .awburst            (awburst),
        .awvalid            (awvalid),
        .awready            (awready),
        .wid                (wid),
        .wdata              (wdata),
        .wstrb              (wstrb),
        .wlast              (wlast),
        .wvalid             (wvalid),
        .wready             (wready),
        .bid                (4'd1),
        .bresp              (bresp),
        .bvalid             (bvalid),
        .bready             (bready)
`ifdef AXI_RESP_CHK_EN
        ,
        .resp_err           (resp_err)
`endif
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [2:0]  axsize;
        logic [3:0]  wstrb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        cyc();
        req = 1'b1; wr = v.wr; size = v.size;
        addr = v.addr; wdat = v.wdata;
        rvalid = 1'b0; bvalid = 1'b0;
        #2;
        chk("idle_addr_ok", 32'(addr_ok), 32'd0);
        chk("idle_data_ok", 32'(data_ok), 32'd0);
        chk("idle_valid", 32'({arvalid, awvalid, wvalid}), 32'd0);
        cyc();
        req = 1'b0; addr = ~v.addr; wdat = ~v.wdata; size = ~v.size;
        if (!v.wr) begin
            arready = 1'b1;
            #2;
            chk("arvalid", 32'(arvalid), 32'd1);
            chk("rd_addr_ok", 32'(addr_ok), 32'd1);
            chk("araddr", araddr, v.addr);
            chk("arsize", 32'(arsize), 32'(v.axsize));
            chk("ar_fixed", {arid, arlen, arburst}, {4'd0, 8'd0, 2'b01});
        end else begin
            awready = 1'b1; wready = 1'b1;
            #2;
            chk("aw_w_valid", 32'({awvalid, wvalid}), 32'd3);
            chk("wr_addr_ok", 32'(addr_ok), 32'd1);
            chk("awaddr", awaddr, v.addr);
            chk("awsize", 32'(awsize), 32'(v.axsize));
            chk("wstrb", 32'(wstrb), 32'(v.wstrb));
            chk("wdata", wdata, v.wdata);
            chk("aw_fixed", {awid, wid, awlen, awburst, wlast},
                {4'd1, 4'd1, 8'd0, 2'b01, 1'b1});
        end
        cyc();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        if (!v.wr) begin
            rvalid = 1'b1; rdata = v.rdata; rresp = 2'b00;
            #2;
            chk("rready", 32'(rready), 32'd1);
            chk("rd_data_ok", 32'(data_ok), 32'd1);
            chk("rd_addr_ok_lo", 32'(addr_ok), 32'd0);
            chk("rdata", c_rdata, v.rdata);
        end else begin
            bvalid = 1'b1; bresp = 2'b00;
            #2;
            chk("bready", 32'(bready), 32'd1);
            chk("wr_data_ok", 32'(data_ok), 32'd1);
            chk("wr_addr_ok_lo", 32'(addr_ok), 32'd0);
        end
    endtask

    task automatic quiesce();
        cyc();
        req = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        #2;
        chk("quiet_data_ok", 32'(data_ok), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd2, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF,
                    3'b010, 4'b1111};
        vecs[1] = '{1'b1, 2'd0, 32'h2000_0003, 32'h1122_3344, 32'h0,
                    3'b000, 4'b1000};
        vecs[2] = '{1'b1, 2'd1, 32'h2000_0002, 32'hA5A5_0000, 32'h0,
                    3'b001, 4'b1100};
        vecs[3] = '{1'b1, 2'd1, 32'h2000_0000, 32'h0000_5A5A, 32'h0,
                    3'b001, 4'b0011};
        vecs[4] = '{1'b1, 2'd3, 32'h3000_0008, 32'hCAFE_F00D, 32'h0,
                    3'b010, 4'b1111};
        vecs[5] = '{1'b0, 2'd0, 32'h4000_0001, 32'h0, 32'h0000_00A5,
                    3'b000, 4'b1111};
        vecs[6] = '{1'b1, 2'd0, 32'h4000_0001, 32'h0000_7700, 32'h0,
                    3'b000, 4'b0010};

        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0;
        addr = '0; wdat = '0; arready = 1'b0; rdata = '0;
        rresp = 2'b00; rvalid = 1'b0; awready = 1'b0;
        wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #2;
        chk("rst_valids",
            32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        chk("rst_oks", 32'({addr_ok, data_ok}), 32'd0);
`ifdef AXI_RESP_CHK_EN
        chk("rst_resp_err", 32'(resp_err), 32'd0);
`endif

        // back-to-back: each vector's req lands in the cycle after data_ok
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);
        quiesce();

        // AW stalled three cycles, W accepted at once
        cyc();
        req = 1'b1; wr = 1'b1; size = 2'd2;
        addr = 32'h7000_0010; wdat = 32'h0BAD_CAFE;
        #2;
        chk("st_idle_ok", 32'(addr_ok), 32'd0);
        cyc();
        wready = 1'b1; awready = 1'b0;
        #2;
        chk("st_c1_valid", 32'({awvalid, wvalid}), 32'd3);
        chk("st_c1_ok", 32'(addr_ok), 32'd0);
        for (int c = 2; c <= 3; c++) begin
            cyc();
            wready = 1'b0; addr = 32'hFFFF_0000 + 32'(c);
            #2;
            chk("st_wait_valid", 32'({awvalid, wvalid}), 32'd2);
            chk("st_wait_ok", 32'(addr_ok), 32'd0);
            chk("st_wait_addr", awaddr, 32'h7000_0010);
        end
        cyc();
        req = 1'b0; awready = 1'b1;
        #2;
        chk("st_aw_valid", 32'({awvalid, wvalid}), 32'd2);
        chk("st_aw_ok", 32'(addr_ok), 32'd1);
        chk("st_wdata", wdata, 32'h0BAD_CAFE);
        cyc();
        awready = 1'b0; bvalid = 1'b1;
        #2;
        chk("st_b_ok", 32'({addr_ok, data_ok}), 32'd1);
        quiesce();

        // AR stalled four cycles while the cache changes its address
        cyc();
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h5000_0010;
        #2;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            addr = 32'h9000_0000 | 32'(c << 4);
            #2;
            chk("ar_stall_valid", 32'(arvalid), 32'd1);
            chk("ar_stall_ok", 32'(addr_ok), 32'd0);
            chk("ar_stall_addr", araddr, 32'h5000_0010);
        end
        cyc();
        arready = 1'b1;
        #2;
        chk("ar_go_ok", 32'(addr_ok), 32'd1);
        chk("ar_go_addr", araddr, 32'h5000_0010);
        cyc();
        req = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1234_5678;
        #2;
        chk("ar_rd_ok", 32'(data_ok), 32'd1);
        chk("ar_rdata", c_rdata, 32'h1234_5678);
        quiesce();

        // reset while waiting for read data
        cyc();
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h6000_0000;
        cyc();
        req = 1'b0; arready = 1'b1;
        #2;
        chk("rr_addr_ok", 32'(addr_ok), 32'd1);
        cyc();
        arready = 1'b0;
        #2;
        chk("rr_rready", 32'(rready), 32'd1);
        chk("rr_no_data", 32'(data_ok), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2;
        chk("rr_after_rst",
            32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        run_vec(vecs[0]);
        quiesce();

`ifdef AXI_RESP_CHK_EN
        cyc();
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h8000_0000;
        cyc();
        req = 1'b0; awready = 1'b1; wready = 1'b1;
        cyc();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
        #2;
        chk("err_data_ok", 32'(data_ok), 32'd1);
        chk("err_pre", 32'(resp_err), 32'd0);
        cyc();
        bvalid = 1'b0; bresp = 2'b00;
        #2;
        chk("err_set", 32'(resp_err), 32'd1);
        run_vec(vecs[5]);
        quiesce();
        chk("err_sticky", 32'(resp_err), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2;
        chk("err_clr", 32'(resp_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_axi_bridge.md
Name: dcache_axi_bridge

Overview:
- Downstream neighbour of the data cache.
- Converts the cache's SRAM-like memory port (req/wr/size/addr/wdata, addr_ok/data_ok) into AXI4 single-beat transactions on the data master port.
- One transaction outstanding at a time: either a read (refill) or a write (dirty write-back or uncached store).
- Sits between the data cache and the SoC AXI crossbar.

Parameters:
- RD_ID, 4'd0, ARID value driven on every read.
- WR_ID, 4'd1, AWID/WID value driven on every write.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cache_data_req  in  1  SRAM-like request; held by master until addr_ok
- cache_data_wr  in  1  1 = write, 0 = read
- cache_data_size  in  2  0 byte, 1 half, 2 word (3 treated as word)
- cache_data_addr  in  32  byte address
- cache_data_wdata  in  32  write data
- cache_data_rdata  out  32  read data, valid when data_ok
- cache_data_addr_ok  out  1  address accepted, one-cycle pulse
- cache_data_data_ok  out  1  transaction complete, one-cycle pulse
- arid/araddr/arlen/arsize/arburst  out  4/32/8/3/2  AR payload
- arvalid  out  1;  arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1;  rready  out  1
- awid/awaddr/awlen/awsize/awburst  out  4/32/8/3/2  AW payload
- awvalid  out  1;  awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1;  wready  in  1
- bid/bresp/bvalid  in  4/2/1;  bready  out  1

Behaviour:
- Reset and clocking: single clock clk; rst synchronous, active-high.
- Reset values: state=IDLE; arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok all 0; aw_done=w_done=0.
- States: IDLE, RADDR, RDATA, WADDR, WRESP.
- IDLE:
  - cache_data_req=1 latches addr, size, wdata, wr into registers.
  - Next state is RADDR (wr=0) or WADDR (wr=1).
  - addr_ok stays 0 in IDLE.
- RADDR:
  - arvalid=1.
  - addr_ok = arvalid & arready (combinational).
  - On the AR handshake, go to RDATA.
- RDATA:
  - rready=1.
  - On rvalid, data_ok=1 and cache_data_rdata=rdata (combinational pass-through); go to IDLE.
- WADDR:
  - awvalid = ~aw_done; wvalid = ~w_done. AW and W are issued in parallel.
  - aw_done/w_done are set on their respective handshakes.
  - addr_ok=1 in the cycle the last outstanding of AW/W completes; this includes both completing in the same cycle. Go to WRESP and clear aw_done/w_done.
- WRESP:
  - bready=1.
  - On bvalid, data_ok=1; go to IDLE.
- Minimum latency:
  - Read: req at cycle 0, addr_ok at cycle 1, data_ok at cycle 2 (zero-wait slave).
  - Write: same timing.
- Payload:
  - araddr/awaddr = latched addr.
  - arlen/awlen = 0; arburst/awburst = 2'b01; wlast = 1.
  - arsize/awsize = {1'b0, size}; size 3 maps to 3'b010.
  - wdata = latched wdata.
- wstrb:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - otherwise: 4'b1111.
- Payload stability: all AXI payloads come from latched registers and stay stable while valid is high, independent of any cache_data_* changes after acceptance.
- cache_data_req outside IDLE is ignored. rid/bid are ignored.
- cache_data_rdata outside RDATA data_ok is don't-care; it is driven as rdata.
- rst asserted in any state: next edge returns all outputs to reset values; the in-flight AXI transaction is abandoned.
- Back-to-back: a req present in the cycle after data_ok is accepted normally; no idle gap is required beyond that cycle.

Optional Feature:
- Macro: AXI_RESP_CHK_EN.
- Defined: adds output resp_err (1 bit, reset 0).
  - Sticky-set on an R handshake with rresp!=0 or a B handshake with bresp!=0.
  - Cleared only by rst.
  - Data still completes normally.
- Undefined: port absent; rresp/bresp ignored.

Test Plan:
- Read word addr 0x1000_0004, arready=1, rvalid one cycle later with rdata=0xDEADBEEF -> araddr=0x1000_0004, arsize=3'b010; addr_ok cycle 1; data_ok + rdata=0xDEADBEEF cycle 2.
- Store byte addr 0x...0003, wdata=0x11223344 -> wstrb=4'b1000, awsize=0; addr_ok only after both AW and W fire.
- Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid held 3 cycles; a single addr_ok pulse when AW fires.
- Read with arready low 4 cycles while cache_data_addr changes -> araddr stays at the latched value; no addr_ok until arready.
- rst asserted in RDATA -> next cycle rready=0, state IDLE; a subsequent read completes correctly.
- With AXI_RESP_CHK_EN: bresp=2'b10 on a write -> data_ok still pulses; resp_err=1 and stays 1 until rst.
